// File: rtl/sgdmac_rd_arbiter_rr.sv
// sgdmac_rd_arbiter_rr: N-channel AXI read arbiter for the SG-DMA engine.
// Round-robin AR arbitration into a single registered AR slot, with the
// channel index as ARID. R beats are routed back by RID. Each channel has an
// outstanding-burst limit. A sticky flag records R beats whose RID maps to no channel.

// Per-channel outstanding-burst counter.
module sgdmac_rd_out_cnt #(
    parameter int MAX_OUT = 4,
    parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic zero
);
    logic [CNT_W-1:0] cnt;
    logic             dec_ok;

    // A decrement at zero is dropped, so late beats after a reset cannot wrap the counter.
    assign dec_ok = dec && (cnt != '0);
    assign full   = (cnt >= CNT_W'(MAX_OUT));
    assign zero   = (cnt == '0);

    // Count AR handshakes up and last R beats down. Both together leave the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (inc && !dec_ok && !full)
            cnt <= cnt + CNT_W'(1);
        else if (dec_ok && !inc)
            cnt <= cnt - CNT_W'(1);
    end
endmodule

module sgdmac_rd_arbiter_rr #(
    parameter int N_CH    = 4,
    parameter int ID_W    = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          ch_arvalid_i,
    output logic [N_CH-1:0]          ch_arready_o,
    input  logic [N_CH*ADDR_W-1:0]   ch_araddr_i,
    input  logic [N_CH*4-1:0]        ch_arlen_i,
    input  logic [N_CH*3-1:0]        ch_arsize_i,
    input  logic [N_CH*2-1:0]        ch_arburst_i,
    output logic                     arvalid_o,
    input  logic                     arready_i,
    output logic [ID_W-1:0]          arid_o,
    output logic [ADDR_W-1:0]        araddr_o,
    output logic [3:0]               arlen_o,
    output logic [2:0]               arsize_o,
    output logic [1:0]               arburst_o,
    input  logic                     rvalid_i,
    input  logic                     rlast_i,
    input  logic [ID_W-1:0]          rid_i,
    input  logic [DATA_W-1:0]        rdata_i,
    input  logic [1:0]               rresp_i,
    output logic                     rready_o,
    output logic [N_CH-1:0]          ch_rvalid_o,
    input  logic [N_CH-1:0]          ch_rready_i,
    output logic [DATA_W-1:0]        ch_rdata_o,
    output logic [1:0]               ch_rresp_o,
    output logic                     ch_rlast_o,
    output logic                     idle_o,
    output logic                     err_o
);
    localparam int PTR_W = $clog2(N_CH);

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [3:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } ar_req_t;

    ar_req_t          ar_q, ar_d;
    logic [PTR_W-1:0] rr_ptr, winner;
    logic [PTR_W:0]   cand;
    logic [N_CH-1:0]  eligible, full, zero, dec;
    logic             load, grant_any, grant, rid_ok;
    logic [PTR_W-1:0] rid_idx;

    assign eligible = ch_arvalid_i & ~full;
    assign load     = !arvalid_o || arready_i;
    assign grant    = load && grant_any;

    // Pick the first eligible channel at or after the round-robin pointer.
    always_comb begin
        grant_any = 1'b0;
        winner    = '0;
        cand      = '0;
        for (int i = 0; i < N_CH; i++) begin
            cand = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(N_CH))
                cand = cand - (PTR_W+1)'(N_CH);
            if (!grant_any && eligible[cand[PTR_W-1:0]]) begin
                grant_any = 1'b1;
                winner    = cand[PTR_W-1:0];
            end
        end
    end

    // Accept the winner and mux its payload. The mux uses constant slices, one per channel.
    always_comb begin
        ch_arready_o = '0;
        if (grant)
            ch_arready_o[winner] = 1'b1;
        ar_d    = '0;
        ar_d.id = ID_W'(winner);
        for (int c = 0; c < N_CH; c++) begin
            if (winner == PTR_W'(c)) begin
                ar_d.addr  = ch_araddr_i[c*ADDR_W +: ADDR_W];
                ar_d.len   = ch_arlen_i[c*4 +: 4];
                ar_d.size  = ch_arsize_i[c*3 +: 3];
                ar_d.burst = ch_arburst_i[c*2 +: 2];
            end
        end
    end

    // AR output slot. It refills whenever it is empty or draining. The payload holds while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arvalid_o <= 1'b0;
            ar_q      <= '0;
            rr_ptr    <= '0;
        end else if (load) begin
            arvalid_o <= grant_any;
            if (grant_any) begin
                ar_q   <= ar_d;
                rr_ptr <= (winner == PTR_W'(N_CH-1)) ? '0 : winner + PTR_W'(1);
            end
        end
    end

    assign arid_o    = ar_q.id;
    assign araddr_o  = ar_q.addr;
    assign arlen_o   = ar_q.len;
    assign arsize_o  = ar_q.size;
    assign arburst_o = ar_q.burst;

    // R routing. A RID beyond the channel range is drained so the bus cannot lock up.
    assign rid_ok  = ({1'b0, rid_i} < (ID_W+1)'(N_CH));
    assign rid_idx = rid_i[PTR_W-1:0];

    // Steer rvalid to the owning channel and take rready back from it.
    always_comb begin
        ch_rvalid_o = '0;
        rready_o    = 1'b1;
        if (rid_ok) begin
            ch_rvalid_o[rid_idx] = rvalid_i;
            rready_o             = ch_rready_i[rid_idx];
        end
    end

    assign ch_rdata_o = rdata_i;
    assign ch_rresp_o = rresp_i;
    assign ch_rlast_o = rlast_i;

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_ch
            assign dec[g] = rvalid_i && rready_o && rlast_i && rid_ok && (rid_idx == PTR_W'(g));
            sgdmac_rd_out_cnt #(.MAX_OUT(MAX_OUT)) u_cnt (
                .clk  (clk),
                .rst  (rst),
                .inc  (ch_arready_o[g]),
                .dec  (dec[g]),
                .full (full[g]),
                .zero (zero[g])
            );
        end
    endgenerate

    // Sticky error flag for R beats whose RID matches no channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_o <= 1'b0;
        else if (rvalid_i && !rid_ok)
            err_o <= 1'b1;
    end

    assign idle_o = !arvalid_o && (&zero);
endmodule

// File: tb/tb_sgdmac_rd_arbiter_rr.sv
// Directed bench for sgdmac_rd_arbiter_rr. Inputs change on the falling edge.
// Checks run 1 ns later, so combinational outputs reflect the new inputs and
// registered outputs reflect the preceding rising edge.
module tb_sgdmac_rd_arbiter_rr;
    localparam int N_CH = 4, ID_W = 4, ADDR_W = 32, DATA_W = 32, MAX_OUT = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_CH-1:0]        ch_arvalid_i, ch_arready_o;
    logic [N_CH*ADDR_W-1:0] ch_araddr_i;
    logic [N_CH*4-1:0]      ch_arlen_i;
    logic [N_CH*3-1:0]      ch_arsize_i;
    logic [N_CH*2-1:0]      ch_arburst_i;
    logic                   arvalid_o, arready_i;
    logic [ID_W-1:0]        arid_o;
    logic [ADDR_W-1:0]      araddr_o;
    logic [3:0]             arlen_o;
    logic [2:0]             arsize_o;
    logic [1:0]             arburst_o;
    logic                   rvalid_i, rlast_i, rready_o;
    logic [ID_W-1:0]        rid_i;
    logic [DATA_W-1:0]      rdata_i;
    logic [1:0]             rresp_i;
    logic [N_CH-1:0]        ch_rvalid_o, ch_rready_i;
    logic [DATA_W-1:0]      ch_rdata_o;
    logic [1:0]             ch_rresp_o;
    logic                   ch_rlast_o, idle_o, err_o;

    int n_chk  = 0;
    int n_pass = 0;

    sgdmac_rd_arbiter_rr #(.N_CH(N_CH), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst(rst),
        .ch_arvalid_i(ch_arvalid_i), .ch_arready_o(ch_arready_o),
        .ch_araddr_i(ch_araddr_i), .ch_arlen_i(ch_arlen_i),
        .ch_arsize_i(ch_arsize_i), .ch_arburst_i(ch_arburst_i),
        .arvalid_o(arvalid_o), .arready_i(arready_i), .arid_o(arid_o),
        .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o), .arburst_o(arburst_o),
        .rvalid_i(rvalid_i), .rlast_i(rlast_i), .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i),
        .rready_o(rready_o), .ch_rvalid_o(ch_rvalid_o), .ch_rready_i(ch_rready_i),
        .ch_rdata_o(ch_rdata_o), .ch_rresp_o(ch_rresp_o), .ch_rlast_o(ch_rlast_o),
        .idle_o(idle_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic set_ch(input int c, input logic [31:0] addr, input logic [3:0] len);
        ch_araddr_i[c*ADDR_W +: ADDR_W] = addr;
        ch_arlen_i[c*4 +: 4]            = len;
        ch_arsize_i[c*3 +: 3]           = 3'd2;
        ch_arburst_i[c*2 +: 2]          = 2'd1;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Pulse reset for one cycle and end on a falling edge with reset released.
    task automatic do_reset();
        cyc();
        ch_arvalid_i = '0; arready_i = 1'b0; rvalid_i = 1'b0; rlast_i = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ch_arvalid_i = '0; ch_araddr_i = '0; ch_arlen_i = '0; ch_arsize_i = '0; ch_arburst_i = '0;
        arready_i = 1'b0; rvalid_i = 1'b0; rlast_i = 1'b0; rid_i = '0;
        rdata_i = '0; rresp_i = '0; ch_rready_i = 4'hF;
        cyc(); #1;
        chk("rst_arvalid", arvalid_o, 0);
        chk("rst_idle", idle_o, 1);
        chk("rst_err", err_o, 0);
        chk("rst_araddr", araddr_o, 0);
        chk("rst_arready", ch_arready_o, 0);
        cyc(); rst = 1'b0;

        // T1: single request from ch1.
        set_ch(1, 32'h1000, 4'd3);
        ch_arvalid_i = 4'b0010; arready_i = 1'b1; #1;
        chk("t1_grant", ch_arready_o, 4'b0010);
        cyc(); ch_arvalid_i = '0; #1;
        chk("t1_arvalid", arvalid_o, 1);
        chk("t1_arid", arid_o, 1);
        chk("t1_araddr", araddr_o, 32'h1000);
        chk("t1_arlen", arlen_o, 3);
        chk("t1_busy", idle_o, 0);
        cyc(); #1;
        chk("t1_drain", arvalid_o, 0);
        chk("t1_outstanding", idle_o, 0);
        rdata_i = 32'hCAFE_0001; rid_i = 4'd1; rlast_i = 1'b1; rvalid_i = 1'b1; #1;
        chk("t1_rvalid", ch_rvalid_o, 4'b0010);
        chk("t1_rready", rready_o, 1);
        chk("t1_rdata", ch_rdata_o, 32'hCAFE_0001);
        cyc(); rvalid_i = 1'b0; rlast_i = 1'b0; #1;
        chk("t1_idle", idle_o, 1);

        // T2: all channels request and grants rotate 0,1,2,3,0.
        do_reset();
        for (int c = 0; c < N_CH; c++) set_ch(c, 32'h100 * (c + 1), 4'(c));
        ch_arvalid_i = 4'hF; arready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("t2_grant%0d", k), ch_arready_o, 4'b0001 << (k % 4));
            if (k > 0) begin
                chk($sformatf("t2_arvalid%0d", k), arvalid_o, 1);
                chk($sformatf("t2_arid%0d", k), arid_o, (k - 1) % 4);
            end
            cyc();
        end
        ch_arvalid_i = '0; #1;
        chk("t2_arid_last", arid_o, 0);
        chk("t2_araddr_last", araddr_o, 32'h100);

        // T3: ch2 is capped at MAX_OUT outstanding bursts.
        do_reset();
        set_ch(2, 32'h2000, 4'd0);
        ch_arvalid_i = 4'b0100; arready_i = 1'b1;
        for (int k = 0; k < MAX_OUT; k++) begin
            #1; chk($sformatf("t3_grant%0d", k), ch_arready_o, 4'b0100);
            cyc();
        end
        #1;
        chk("t3_blocked", ch_arready_o, 0);
        chk("t3_last_ar", arvalid_o, 1);
        cyc(); #1;
        chk("t3_blocked2", ch_arready_o, 0);
        chk("t3_empty", arvalid_o, 0);
        rid_i = 4'd2; rlast_i = 1'b1; rvalid_i = 1'b1; #1;
        chk("t3_blocked_rbeat", ch_arready_o, 0);
        chk("t3_rready", rready_o, 1);
        cyc(); rvalid_i = 1'b0; rlast_i = 1'b0; #1;
        chk("t3_unblocked", ch_arready_o, 4'b0100);
        cyc(); ch_arvalid_i = '0;

        // T4: AXI stall holds the payload. Release gives exactly one handshake.
        do_reset();
        set_ch(0, 32'hA0, 4'd1); set_ch(1, 32'hB0, 4'd2);
        ch_arvalid_i = 4'b0001; arready_i = 1'b0; #1;
        chk("t4_grant", ch_arready_o, 4'b0001);
        cyc(); ch_arvalid_i = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("t4_hold_rdy%0d", k), ch_arready_o, 0);
            chk($sformatf("t4_hold_addr%0d", k), araddr_o, 32'hA0);
            chk($sformatf("t4_hold_id%0d", k), arid_o, 0);
            chk($sformatf("t4_hold_vld%0d", k), arvalid_o, 1);
            cyc();
        end
        ch_arvalid_i = '0; arready_i = 1'b1; #1;
        chk("t4_release_vld", arvalid_o, 1);
        cyc(); #1;
        chk("t4_one_hs", arvalid_o, 0);

        // T5: R routing with backpressure, then a stray RID.
        do_reset();
        ch_rready_i = 4'b0111; rid_i = 4'd3; rvalid_i = 1'b1; rlast_i = 1'b0; #1;
        chk("t5_rready_bp", rready_o, 0);
        chk("t5_rvalid3", ch_rvalid_o, 4'b1000);
        chk("t5_no_err", err_o, 0);
        cyc(); rid_i = 4'd7; #1;
        chk("t5_stray_rready", rready_o, 1);
        chk("t5_stray_rvalid", ch_rvalid_o, 0);
        cyc(); rvalid_i = 1'b0; #1;
        chk("t5_err", err_o, 1);
        ch_rready_i = 4'hF; rid_i = 4'd3; rlast_i = 1'b1; rvalid_i = 1'b1;
        cyc(); rvalid_i = 1'b0; rlast_i = 1'b0; #1;
        chk("t5_err_sticky", err_o, 1);
        chk("t5_no_underflow", idle_o, 1);

        // T6: asynchronous reset with two bursts outstanding and AR valid.
        do_reset();
        set_ch(0, 32'hC0, 4'd0); set_ch(1, 32'hD0, 4'd0);
        ch_arvalid_i = 4'b0011; arready_i = 1'b0;
        cyc(); ch_arvalid_i = 4'b0010;
        cyc(); arready_i = 1'b1; #1;
        chk("t6_grant1", ch_arready_o, 4'b0010);
        cyc(); ch_arvalid_i = '0; arready_i = 1'b0;
        rid_i = 4'd9; rvalid_i = 1'b1;
        cyc(); rvalid_i = 1'b0; #1;
        chk("t6_pre_vld", arvalid_o, 1);
        chk("t6_pre_err", err_o, 1);
        chk("t6_pre_idle", idle_o, 0);
        #1; rst = 1'b1; #1;
        chk("t6_rst_vld", arvalid_o, 0);
        chk("t6_rst_idle", idle_o, 1);
        chk("t6_rst_err", err_o, 0);
        cyc(); rst = 1'b0;
        rid_i = 4'd1; rlast_i = 1'b1; rvalid_i = 1'b1;
        cyc(); rvalid_i = 1'b0; rlast_i = 1'b0; #1;
        chk("t6_clamp_idle", idle_o, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
